io_read_ctrl: RTL and testbench

Sequencer that owns the switch/enter input path for CPU I/O reads. On a CPU read request it selects the requested switch byte, stalls the CPU, waits for a clean debounced press of the enter button, latches the byte and completes the read with a one-cycle valid pulse. It sits between the controller/memorio read path and the board switches and button, and replaces ad-hoc edge detection with a synchronized, debounced, handshaked capture.

---
 rtl/io_pkg.sv | 25 ++
 rtl/io_read_ctrl_if.sv | 22 ++
 rtl/io_debounce.sv | 62 ++++++
 rtl/io_read_ctrl.sv | 103 ++++++++++
 tb/tb_io_read_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the CPU I/O read path.
package io_pkg;

   localparam int unsigned SW_W   = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARM        = 3'd1,
      RELEASE    = 3'd2,
      WAIT_PRESS = 3'd3,
      DONE       = 3'd4
   } io_state_e;

   localparam logic              SW_HI     = 1'b1;
   localparam logic              SW_LO     = 1'b0;
   localparam logic [BYTE_W-1:0] IO_NODATA = 8'h00;

   // Pick the upper or lower switch byte.
   function automatic logic [BYTE_W-1:0] sw_byte(input logic [SW_W-1:0] sw,
                                                  input logic            half);
      return (half == SW_HI) ? sw[SW_W-1:BYTE_W] : sw[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/io_read_ctrl_if.sv
// CPU-side read handshake between the controller and io_read_ctrl.
interface io_read_ctrl_if;
   import io_pkg::*;

   logic              io_req;
   logic              sel_hi;
   logic              sel_lo;
   logic [BYTE_W-1:0] io_rdata;
   logic              io_valid;
   logic              cpu_stall;

   modport master (
      output io_req, sel_hi, sel_lo,
      input  io_rdata, io_valid, cpu_stall
   );

   modport slave (
      input  io_req, sel_hi, sel_lo,
      output io_rdata, io_valid, cpu_stall
   );

endinterface

// File: rtl/io_debounce.sv
// Synchronizes and debounces the enter button, emitting a one-cycle press pulse.
module io_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Stable level flips only after an unbroken run of differing samples.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else if (sync2_q == stable_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_q <= ~stable_q;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Registered rising-edge pulse of the debounced level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stable_d_q <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         stable_d_q <= stable_q;
         press_q    <= stable_q & ~stable_d_q;
      end
   end

   assign stable = stable_q;
   assign press  = press_q;

endmodule

// File: rtl/io_read_ctrl.sv
// CPU I/O read sequencer: stalls the CPU until the operator confirms a switch byte.
module io_read_ctrl
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   io_read_ctrl_if.slave    bus,
   input  logic [SW_W-1:0]  switch_in,
   input  logic             enter_btn,
   output logic             wait_led
);

   io_state_e         state_q;
   logic              half_q;
   logic [BYTE_W-1:0] rdata_q;
   logic              valid_q;
   logic              wait_q;
   logic              btn_stable;
   logic              btn_press;

   io_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (enter_btn),
      .stable (btn_stable),
      .press  (btn_press)
   );

   // Request sequencing, byte capture and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         half_q  <= SW_LO;
         rdata_q <= IO_NODATA;
         valid_q <= 1'b0;
         wait_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         wait_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.io_req) begin
                  if (bus.sel_hi | bus.sel_lo) begin
                     half_q  <= bus.sel_hi ? SW_HI : SW_LO;
                     state_q <= ARM;
                  end else begin
                     rdata_q <= IO_NODATA;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            // A button already held at request time must be released first.
            ARM: begin
               if (!bus.io_req) begin
                  state_q <= IDLE;
               end else begin
                  wait_q  <= 1'b1;
                  state_q <= btn_stable ? RELEASE : WAIT_PRESS;
               end
            end
            RELEASE: begin
               if (!bus.io_req) begin
                  state_q <= IDLE;
               end else begin
                  wait_q <= 1'b1;
                  if (!btn_stable) begin
                     state_q <= WAIT_PRESS;
                  end
               end
            end
            // Abort takes priority over a coincident press.
            WAIT_PRESS: begin
               if (!bus.io_req) begin
                  state_q <= IDLE;
               end else if (btn_press) begin
                  rdata_q <= sw_byte(switch_in, half_q);
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  wait_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.io_rdata  = rdata_q;
   assign bus.io_valid  = valid_q;
   assign bus.cpu_stall = bus.io_req & (state_q != DONE);
   assign wait_led      = wait_q;

endmodule

// File: tb/tb_io_read_ctrl.sv
// Randomized and directed bench for io_read_ctrl against a behavioural model.
module tb_io_read_ctrl;

   localparam int unsigned DB = 4;

   logic        clk;
   logic        reset;
   logic [15:0] switch_in;
   logic        enter_btn;
   logic        wait_led;

   io_read_ctrl_if bus ();

   io_read_ctrl #(
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .switch_in (switch_in),
      .enter_btn (enter_btn),
      .wait_led  (wait_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Behavioural model: button history windows and a request tracker.
   bit         raw_log[$];
   bit         syn_log[$];
   bit         m_stable, m_rise1, m_rise2;
   bit         m_busy, m_checked, m_need_rel, m_ack, m_half, m_wait;
   logic [7:0] m_rdata = 8'h00;

   task automatic mdl_edge();
      bit syn, stable_seen, press_seen, all_diff, rose;
      if (!reset) begin
         raw_log.delete();
         raw_log.push_back(1'b0);
         raw_log.push_back(1'b0);
         syn_log.delete();
         m_stable = 0; m_rise1 = 0; m_rise2 = 0;
         m_busy = 0; m_checked = 0; m_need_rel = 0; m_ack = 0; m_wait = 0;
         m_rdata = 8'h00;
      end else begin
         stable_seen = m_stable;
         press_seen  = m_rise2;
         // Request tracking: one accept cycle, optional release wait, then a press.
         if (m_ack) begin
            m_ack = 0;
         end else if (!m_busy) begin
            if (bus.io_req) begin
               if (bus.sel_hi | bus.sel_lo) begin
                  m_busy = 1; m_checked = 0; m_half = bus.sel_hi;
               end else begin
                  m_rdata = 8'h00; m_ack = 1;
               end
            end
         end else if (!bus.io_req) begin
            m_busy = 0;
         end else if (!m_checked) begin
            m_checked  = 1;
            m_need_rel = stable_seen;
         end else if (m_need_rel) begin
            if (!stable_seen) m_need_rel = 0;
         end else if (press_seen) begin
            m_rdata = m_half ? switch_in[15:8] : switch_in[7:0];
            m_ack   = 1;
            m_busy  = 0;
         end
         m_wait = m_busy & m_checked;
         // Button: synchronized sample is the raw value two edges back.
         syn = (raw_log.size() >= 2) ? raw_log[raw_log.size()-2] : 1'b0;
         raw_log.push_back(enter_btn);
         if (raw_log.size() > 4) void'(raw_log.pop_front());
         syn_log.push_back(syn);
         if (syn_log.size() > DB) void'(syn_log.pop_front());
         rose = 0;
         if (syn_log.size() == DB) begin
            all_diff = 1;
            foreach (syn_log[i]) if (syn_log[i] == m_stable) all_diff = 0;
            if (all_diff) begin
               m_stable = ~m_stable;
               rose     = m_stable;
               syn_log.delete();
            end
         end
         m_rise2 = m_rise1;
         m_rise1 = rose;
      end
   endtask

   task automatic step();
      @(posedge clk);
      mdl_edge();
      @(negedge clk);
      if (chk_en) begin
         chk("m_valid", 32'(bus.io_valid), 32'(m_ack));
         chk("m_stall", 32'(bus.cpu_stall), 32'(bus.io_req & ~m_ack));
         chk("m_wait",  32'(wait_led), 32'(m_wait));
         chk("m_rdata", 32'(bus.io_rdata), 32'(m_rdata));
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_valid(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         if (bus.io_valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_valid(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (bus.io_valid === 1'b1) cnt++;
      end
   endtask

   initial begin
      int         n, cnt;
      logic [15:0] r;
      logic [7:0]  prev;

      // Reset with random inputs.
      reset      = 1'b0;
      bus.io_req = 1'($urandom_range(1));
      bus.sel_hi = 1'($urandom_range(1));
      bus.sel_lo = 1'($urandom_range(1));
      switch_in  = 16'($urandom);
      enter_btn  = 1'($urandom_range(1));
      step();
      chk_en = 1'b1;
      step();
      chk("rst_rdata", 32'(bus.io_rdata), 32'h00);
      chk("rst_valid", 32'(bus.io_valid), 32'h0);
      chk("rst_wait",  32'(wait_led), 32'h0);
      chk("rst_stall", 32'(bus.cpu_stall), 32'(bus.io_req));
      reset = 1'b1; bus.io_req = 1'b0; enter_btn = 1'b0;
      steps(8);

      // Upper-byte read with a clean press.
      switch_in = 16'hA55A; bus.sel_hi = 1'b1; bus.sel_lo = 1'b0; bus.io_req = 1'b1;
      step();
      chk("hi_stall", 32'(bus.cpu_stall), 32'h1);
      steps(2);
      chk("hi_wait", 32'(wait_led), 32'h1);
      enter_btn = 1'b1;
      wait_valid(20, n);
      chk("hi_latency", 32'(n - 1), 32'd7);
      chk("hi_rdata", 32'(bus.io_rdata), 32'hA5);
      chk("hi_stall_done", 32'(bus.cpu_stall), 32'h0);
      bus.io_req = 1'b0;
      count_valid(6, cnt);
      chk("hi_single_pulse", 32'(cnt), 32'd0);
      enter_btn = 1'b0;
      steps(8);

      // Button held before the request must be released first.
      enter_btn = 1'b1;
      steps(10);
      switch_in = 16'h1234; bus.sel_hi = 1'b0; bus.sel_lo = 1'b1; bus.io_req = 1'b1;
      count_valid(15, cnt);
      chk("held_no_done", 32'(cnt), 32'd0);
      chk("held_wait", 32'(wait_led), 32'h1);
      enter_btn = 1'b0;
      count_valid(10, cnt);
      chk("held_rel_no_done", 32'(cnt), 32'd0);
      enter_btn = 1'b1;
      wait_valid(20, n);
      chk("held_latency", 32'(n - 1), 32'd7);
      chk("held_rdata", 32'(bus.io_rdata), 32'h34);
      bus.io_req = 1'b0; enter_btn = 1'b0;
      steps(8);

      // Bounce: toggles every 2 cycles never complete, final hold does.
      r = 16'($urandom);
      switch_in = r; bus.sel_hi = 1'b0; bus.sel_lo = 1'b1; bus.io_req = 1'b1;
      steps(3);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         enter_btn = ~enter_btn;
         step(); if (bus.io_valid === 1'b1) cnt++;
         step(); if (bus.io_valid === 1'b1) cnt++;
      end
      chk("bounce_no_press", 32'(cnt), 32'd0);
      enter_btn = 1'b1;
      wait_valid(20, n);
      chk("bounce_latency", 32'(n - 1), 32'd7);
      chk("bounce_rdata", 32'(bus.io_rdata), 32'(r[7:0]));
      bus.io_req = 1'b0; enter_btn = 1'b0;
      steps(8);

      // Abort in WAIT_PRESS, then a press: nothing captured.
      prev = r[7:0];
      switch_in = 16'($urandom); bus.sel_hi = 1'b1; bus.sel_lo = 1'b0; bus.io_req = 1'b1;
      steps(3);
      bus.io_req = 1'b0; enter_btn = 1'b1;
      count_valid(12, cnt);
      chk("abort_no_valid", 32'(cnt), 32'd0);
      chk("abort_rdata", 32'(bus.io_rdata), 32'(prev));
      enter_btn = 1'b0;
      steps(8);

      // Both selects set: upper byte wins.
      switch_in = 16'hBEEF; bus.sel_hi = 1'b1; bus.sel_lo = 1'b1; bus.io_req = 1'b1;
      steps(3);
      enter_btn = 1'b1;
      wait_valid(20, n);
      chk("both_latency", 32'(n - 1), 32'd7);
      chk("both_rdata", 32'(bus.io_rdata), 32'hBE);
      bus.io_req = 1'b0; enter_btn = 1'b0;
      steps(8);

      // No select: immediate completion with the empty byte.
      bus.sel_hi = 1'b0; bus.sel_lo = 1'b0; bus.io_req = 1'b1;
      step();
      chk("nosel_valid", 32'(bus.io_valid), 32'h1);
      chk("nosel_rdata", 32'(bus.io_rdata), 32'h00);
      chk("nosel_stall", 32'(bus.cpu_stall), 32'h0);
      bus.io_req = 1'b0;
      steps(2);

      // Reset during a debounce count: full count needed afterwards.
      enter_btn = 1'b1;
      steps(3);
      reset = 1'b0;
      step();
      reset = 1'b1;
      r = 16'($urandom);
      switch_in = r; bus.sel_hi = 1'b0; bus.sel_lo = 1'b1; bus.io_req = 1'b1;
      wait_valid(20, n);
      chk("rstdb_latency", 32'(n - 1), 32'd7);
      chk("rstdb_rdata", 32'(bus.io_rdata), 32'(r[7:0]));
      bus.io_req = 1'b0; enter_btn = 1'b0;
      steps(8);

      // Random traffic, bouncy button, aborts and occasional reset.
      for (int c = 0; c < 1500; c++) begin
         step();
         if (bus.io_req && bus.io_valid === 1'b1) begin
            bus.io_req = 1'b0;
         end else if (!bus.io_req && $urandom_range(3) == 0) begin
            bus.io_req = 1'b1;
            bus.sel_hi = 1'($urandom_range(1));
            bus.sel_lo = 1'($urandom_range(1));
         end else if (bus.io_req && $urandom_range(59) == 0) begin
            bus.io_req = 1'b0;
         end
         if ($urandom_range(7) == 0) switch_in = 16'($urandom);
         if ($urandom_range(5) == 0) enter_btn = ~enter_btn;
         reset = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      end
      reset = 1'b1; bus.io_req = 1'b0;
      steps(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
